// File: rtl/power_frame_ctrl.sv
// Spectrum power frame sequencer: aligns FFT bins through an external squarer into the spectrum buffer,
// tracks the per-frame peak bin, flags length errors and supports single-shot or continuous capture.
module power_frame_ctrl #(
   parameter int NFFT_LOG2 = 10,
   parameter int SQ_LAT    = 2,
   parameter bit SKIP_DC   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 cfg_continuous,
   input  logic                 fft_valid,
   input  logic                 fft_last,
   input  logic [31:0]          fft_real,
   input  logic [31:0]          fft_imag,
   output logic [31:0]          sq_real,
   output logic [31:0]          sq_imag,
   input  logic [63:0]          sq_data,
   input  logic                 buf_busy,
   output logic                 buf_wr_en,
   output logic [NFFT_LOG2-1:0] buf_wr_addr,
   output logic [63:0]          buf_wr_data,
   output logic                 busy,
   output logic                 frame_done,
   output logic [NFFT_LOG2-1:0] peak_bin,
   output logic [63:0]          peak_pow,
   output logic [15:0]          frame_cnt,
   output logic                 err_len
);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAP, S_FLUSH, S_DONE} state_t;

   localparam logic [NFFT_LOG2-1:0] FIRST_BIN = SKIP_DC ? NFFT_LOG2'(1) : '0;

   state_t               state, state_n;
   logic                 in_sync, bnd, cont;
   logic [NFFT_LOG2-1:0] bin_cnt;
   logic [SQ_LAT:0]      vld_p;
   logic [NFFT_LOG2-1:0] bin_p [SQ_LAT+1];
   logic [63:0]          run_pow;
   logic [NFFT_LOG2-1:0] run_bin;
   logic                 frame_go, beat, beat_top, beat_end, beat_err, wr_en;
   logic [NFFT_LOG2-1:0] beat_bin;

   // bnd marks that the previous valid beat closed a frame, so the next valid beat is bin 0
   assign frame_go = (state == S_ARM) && fft_valid && in_sync && bnd && !buf_busy;
   assign beat     = frame_go || ((state == S_CAP) && fft_valid);
   assign beat_bin = frame_go ? '0 : bin_cnt;
   assign beat_top = (beat_bin == '1);
   assign beat_end = beat && (fft_last || beat_top);
   assign beat_err = beat && (fft_last != beat_top);
   assign wr_en    = vld_p[SQ_LAT];

   always_comb begin
      state_n     = state;
      busy        = (state != S_IDLE);
      frame_done  = 1'b0;
      buf_wr_en   = wr_en;
      buf_wr_addr = '0;
      buf_wr_data = '0;
      if (wr_en) begin
         buf_wr_addr = bin_p[SQ_LAT];
         buf_wr_data = sq_data;
      end
      case (state)
         S_IDLE:  if (start) state_n = S_ARM;
         S_ARM:   if (frame_go) state_n = beat_end ? S_FLUSH : S_CAP;
         S_CAP:   if (beat_end) state_n = S_FLUSH;
         // the entry in the last slot is written this cycle, so only the earlier slots must drain
         S_FLUSH: if (vld_p[SQ_LAT-1:0] == '0) state_n = S_DONE;
         S_DONE: begin
            frame_done = 1'b1;
            state_n    = cont ? S_ARM : S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         in_sync   <= 1'b0;
         bnd       <= 1'b0;
         cont      <= 1'b0;
         err_len   <= 1'b0;
         bin_cnt   <= '0;
         vld_p     <= '0;
         sq_real   <= '0;
         sq_imag   <= '0;
         run_pow   <= '0;
         run_bin   <= '0;
         peak_bin  <= '0;
         peak_pow  <= '0;
         frame_cnt <= '0;
      end else begin
         state <= state_n;
         if (fft_valid) begin
            bnd <= fft_last;
            if (fft_last) in_sync <= 1'b1;
         end
         if ((state == S_IDLE) && start) begin
            cont    <= cfg_continuous;
            err_len <= 1'b0;
         end else if (beat_err) begin
            err_len <= 1'b1;
         end
         // stage 0: operands into the squarer, valid enters the alignment pipe
         vld_p <= {vld_p[SQ_LAT-1:0], beat};
         if (beat) begin
            bin_cnt <= beat_bin + 1'b1;
            sq_real <= fft_real;
            sq_imag <= fft_imag;
         end
         // stage SQ_LAT: result aligned with its bin, peak search on the written value
         if (wr_en) begin
            if (bin_p[SQ_LAT] == '0) begin
               run_pow <= SKIP_DC ? '0 : sq_data;
               run_bin <= FIRST_BIN;
            end else if (sq_data > run_pow) begin
               run_pow <= sq_data;
               run_bin <= bin_p[SQ_LAT];
            end
         end
         if (state == S_DONE) begin
            peak_bin  <= run_bin;
            peak_pow  <= run_pow;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      bin_p[0] <= beat_bin;
      for (int i = 1; i <= SQ_LAT; i++) bin_p[i] <= bin_p[i-1];
   end

endmodule

// File: tb/tb_power_frame_ctrl.sv
// Directed bench for power_frame_ctrl: external squarer model, write monitor, and a linear sequence of frame scenarios.
module tb_power_frame_ctrl;

   localparam int NFFT = 1024;
   localparam int LAT  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, cfg_continuous, fft_valid, fft_last, buf_busy;
   logic [31:0] fft_real, fft_imag;
   logic [31:0] sq_real, sq_imag, z_sq_real, z_sq_imag;
   logic [63:0] sq_data, z_sq_data, buf_wr_data, z_buf_wr_data, peak_pow, z_peak_pow;
   logic        buf_wr_en, z_buf_wr_en, busy, z_busy, frame_done, z_frame_done, err_len, z_err_len;
   logic [9:0]  buf_wr_addr, z_buf_wr_addr, peak_bin, z_peak_bin;
   logic [15:0] frame_cnt, z_frame_cnt;

   power_frame_ctrl #(.NFFT_LOG2(10), .SQ_LAT(2), .SKIP_DC(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_continuous(cfg_continuous),
      .fft_valid(fft_valid), .fft_last(fft_last), .fft_real(fft_real), .fft_imag(fft_imag),
      .sq_real(sq_real), .sq_imag(sq_imag), .sq_data(sq_data), .buf_busy(buf_busy),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .busy(busy), .frame_done(frame_done), .peak_bin(peak_bin), .peak_pow(peak_pow),
      .frame_cnt(frame_cnt), .err_len(err_len)
   );

   power_frame_ctrl #(.NFFT_LOG2(10), .SQ_LAT(2), .SKIP_DC(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .cfg_continuous(cfg_continuous),
      .fft_valid(fft_valid), .fft_last(fft_last), .fft_real(fft_real), .fft_imag(fft_imag),
      .sq_real(z_sq_real), .sq_imag(z_sq_imag), .sq_data(z_sq_data), .buf_busy(buf_busy),
      .buf_wr_en(z_buf_wr_en), .buf_wr_addr(z_buf_wr_addr), .buf_wr_data(z_buf_wr_data),
      .busy(z_busy), .frame_done(z_frame_done), .peak_bin(z_peak_bin), .peak_pow(z_peak_pow),
      .frame_cnt(z_frame_cnt), .err_len(z_err_len)
   );

   function automatic logic [63:0] pow(input logic [31:0] re, input logic [31:0] im);
      logic signed [63:0] a, b;
      a = {{32{re[31]}}, re};
      b = {{32{im[31]}}, im};
      return a * a + b * b;
   endfunction

   function automatic logic [31:0] re_of(input int mode, input int k);
      case (mode)
         0:       return k;
         1:       return (k == 0) ? 32'd7 : (k == 5) ? 32'hFFFF_FFFD : 32'd0;
         2:       return (k == 9) ? 32'd10 : (k == 20) ? 32'd6 : 32'd0;
         default: return (k == 100) ? 32'h8000_0000 : k * 37 - 5000;
      endcase
   endfunction

   function automatic logic [31:0] im_of(input int mode, input int k);
      case (mode)
         0:       return 32'd0;
         1:       return (k == 5) ? 32'd4 : 32'd0;
         2:       return (k == 20) ? 32'd8 : 32'd0;
         default: return (k == 100) ? 32'h8000_0000 : 3000 - k * 11;
      endcase
   endfunction

   // two-cycle squarer behind each DUT
   logic [63:0] sqa_p0, sqa_p1, sqb_p0, sqb_p1;
   always @(posedge clk) begin
      sqa_p0 <= pow(sq_real, sq_imag);
      sqa_p1 <= sqa_p0;
      sqb_p0 <= pow(z_sq_real, z_sq_imag);
      sqb_p1 <= sqb_p0;
   end
   assign sq_data   = sqa_p1;
   assign z_sq_data = sqb_p1;

   int          cyc = 0;
   int          wr_tot = 0, data_bad = 0, lat_bad = 0, ord_bad = 0, done_tot = 0;
   logic [63:0] exp_pow [NFFT];
   int          beat_cyc [NFFT];
   logic [63:0] got_pow [NFFT];
   logic [9:0]  prev_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (buf_wr_en) begin
         wr_tot <= wr_tot + 1;
         got_pow[buf_wr_addr] <= buf_wr_data;
         if (buf_wr_data !== exp_pow[buf_wr_addr]) data_bad <= data_bad + 1;
         if (cyc - beat_cyc[buf_wr_addr] != LAT) lat_bad <= lat_bad + 1;
         if (buf_wr_addr != 10'd0 && int'(buf_wr_addr) != int'(prev_addr) + 1) ord_bad <= ord_bad + 1;
         prev_addr <= buf_wr_addr;
      end
      if (frame_done) done_tot <= done_tot + 1;
   end

   int n_vec = 0, n_err = 0;
   int w0, d0, l0, o0, f0, w1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic snap();
      w0 = wr_tot; d0 = data_bad; l0 = lat_bad; o0 = ord_bad; f0 = done_tot;
   endtask

   task automatic chk_frame(input string tag, input int nwr, input int ndone);
      chk($sformatf("%s.writes", tag), 64'(wr_tot - w0), 64'(nwr));
      chk($sformatf("%s.data", tag), 64'(data_bad - d0), 64'd0);
      chk($sformatf("%s.latency", tag), 64'(lat_bad - l0), 64'd0);
      chk($sformatf("%s.order", tag), 64'(ord_bad - o0), 64'd0);
      chk($sformatf("%s.done_pulses", tag), 64'(done_tot - f0), 64'(ndone));
   endtask

   task automatic pulse_start(input logic cont);
      cfg_continuous = cont;
      start = 1'b1;
      tick();
      start = 1'b0;
      cfg_continuous = 1'b0;
   endtask

   task automatic send_frame(input int n, input int mode, input int rec_n, input int busy_n, input bit gaps);
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            fft_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         fft_valid = 1'b1;
         fft_real  = re_of(mode, k);
         fft_imag  = im_of(mode, k);
         fft_last  = (k == n - 1);
         buf_busy  = (k < busy_n);
         if (k < rec_n) begin
            exp_pow[k]  = pow(fft_real, fft_imag);
            beat_cyc[k] = cyc;
         end
         tick();
      end
      fft_valid = 1'b0;
      fft_last  = 1'b0;
      buf_busy  = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_continuous = 1'b0; fft_valid = 1'b0; fft_last = 1'b0;
      buf_busy = 1'b0; fft_real = '0; fft_imag = '0;
      for (int i = 0; i < NFFT; i++) begin exp_pow[i] = '0; beat_cyc[i] = 0; end
      repeat (3) tick();
      rst = 1'b0;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.wr_en", 64'(buf_wr_en), 64'd0);
      chk("rst.frame_done", 64'(frame_done), 64'd0);
      chk("rst.err_len", 64'(err_len), 64'd0);
      chk("rst.frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst.peak_bin", 64'(peak_bin), 64'd0);
      chk("rst.peak_pow", peak_pow, 64'd0);
      chk("rst.sq_real", 64'(sq_real), 64'd0);

      // single shot: first frame has no sync and is skipped, second is captured
      pulse_start(1'b0);
      chk("t1.armed", 64'(busy), 64'd1);
      snap();
      send_frame(NFFT, 0, 0, 0, 1'b0);
      chk_frame("t1.junk", 0, 0);
      chk("t1.still_armed", 64'(busy), 64'd1);
      snap();
      send_frame(NFFT, 0, NFFT, 0, 1'b0);
      chk_frame("t1.ramp", NFFT, 1);
      chk("t1.peak_bin", 64'(peak_bin), 64'd1023);
      chk("t1.peak_pow", peak_pow, 64'd1046529);
      chk("t1.frame_cnt", 64'(frame_cnt), 64'd1);
      chk("t1.idle", 64'(busy), 64'd0);
      chk("t1.err_len", 64'(err_len), 64'd0);

      pulse_start(1'b0);
      snap();
      send_frame(NFFT, 1, NFFT, 0, 1'b0);
      chk_frame("t2", NFFT, 1);
      chk("t2.addr5", got_pow[5], 64'd25);
      chk("t2.peak_bin", 64'(peak_bin), 64'd5);
      chk("t2.peak_pow", peak_pow, 64'd25);
      chk("t2.dc_peak_bin", 64'(z_peak_bin), 64'd0);
      chk("t2.dc_peak_pow", z_peak_pow, 64'd49);
      chk("t2.frame_cnt", 64'(frame_cnt), 64'd2);

      pulse_start(1'b0);
      snap();
      send_frame(NFFT, 2, NFFT, 0, 1'b0);
      chk_frame("t3", NFFT, 1);
      chk("t3.tie_peak_bin", 64'(peak_bin), 64'd9);
      chk("t3.tie_peak_pow", peak_pow, 64'd100);
      chk("t3.dc_tie_peak_bin", 64'(z_peak_bin), 64'd9);
      chk("t3.frame_cnt", 64'(frame_cnt), 64'd3);

      // early fft_last at bin 700, with a full-scale bin that only an unsigned compare ranks highest
      pulse_start(1'b0);
      snap();
      send_frame(701, 3, 701, 0, 1'b0);
      chk_frame("t5.short", 701, 1);
      chk("t5.err_len", 64'(err_len), 64'd1);
      chk("t5.peak_bin", 64'(peak_bin), 64'd100);
      chk("t5.peak_pow", peak_pow, 64'h8000_0000_0000_0000);
      chk("t5.frame_cnt", 64'(frame_cnt), 64'd4);
      chk("t5.idle", 64'(busy), 64'd0);

      pulse_start(1'b1);
      chk("t5.start_clears_err", 64'(err_len), 64'd0);
      chk("c.armed", 64'(busy), 64'd1);
      snap();
      send_frame(NFFT, 0, NFFT, 0, 1'b0);
      chk_frame("c1", NFFT, 1);
      chk("c1.frame_cnt", 64'(frame_cnt), 64'd5);
      snap();
      send_frame(NFFT, 0, 0, 4, 1'b0);
      chk_frame("c2.busy_skip", 0, 0);
      chk("c2.frame_cnt", 64'(frame_cnt), 64'd5);
      chk("c2.still_armed", 64'(busy), 64'd1);
      snap();
      send_frame(NFFT, 2, NFFT, 0, 1'b0);
      chk_frame("c3", NFFT, 1);
      chk("c3.frame_cnt", 64'(frame_cnt), 64'd6);
      chk("c3.err_len", 64'(err_len), 64'd0);
      chk("c3.dc_frame_cnt", 64'(z_frame_cnt), 64'd6);

      // overlong frame: capture stops at bin NFFT-1, the tail is ignored
      snap();
      send_frame(NFFT + 6, 0, NFFT, 0, 1'b0);
      chk_frame("c4.long", NFFT, 1);
      chk("c4.err_len", 64'(err_len), 64'd1);
      chk("c4.frame_cnt", 64'(frame_cnt), 64'd7);

      snap();
      send_frame(NFFT, 3, NFFT, 0, 1'b1);
      chk_frame("c5.gaps", NFFT, 1);
      chk("c5.frame_cnt", 64'(frame_cnt), 64'd8);

      // reset in the middle of a gapped frame
      snap();
      for (int k = 0; k <= 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            fft_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
         end
         fft_valid   = 1'b1;
         fft_real    = re_of(0, k);
         fft_imag    = 32'd0;
         fft_last    = 1'b0;
         exp_pow[k]  = pow(fft_real, fft_imag);
         beat_cyc[k] = cyc;
         if (k == 300) rst = 1'b1;
         tick();
      end
      rst = 1'b0;
      fft_valid = 1'b0;
      chk("r.busy", 64'(busy), 64'd0);
      chk("r.frame_cnt", 64'(frame_cnt), 64'd0);
      chk("r.peak_bin", 64'(peak_bin), 64'd0);
      chk("r.peak_pow", peak_pow, 64'd0);
      chk("r.err_len", 64'(err_len), 64'd0);
      w1 = wr_tot;
      repeat (8) tick();
      chk("r.no_writes", 64'(wr_tot - w1), 64'd0);
      chk("r.no_done", 64'(done_tot - f0), 64'd0);
      chk("r.order", 64'(ord_bad - o0), 64'd0);
      chk("r.data", 64'(data_bad - d0), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
